// File: rtl/hit_deserializer_45.sv
// Hit-serial link receiver: frames six 16-bit words into a 77-bit track combination,
// checks framing/format, and queues combinations and end-of-event markers in a FWFT FIFO.
module hit_deserializer_45 #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [15:0]   in_word,
  input  logic          in_dv,
  input  logic          in_ev,
  input  logic          in_ee,
  output logic [76:0]   out_rec,
  output logic          out_is_ee,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          frame_err,
  output logic          fmt_err,
  output logic          overflow,
  output logic [AW:0]   fifo_level
);

  typedef enum logic {IDLE, COLLECT} state_t;

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [15:0] wbuf [5];
  logic        store;
  logic        frame_err_c, fmt_err_c;
  logic        push_rec, push_ee, push, pop, full, push_ok;
  logic        fmt_ok;
  logic [76:0] rec;
  logic [77:0] push_data;

  logic [77:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // Sixth word is checked straight off the link; words 0..4 come from the buffer.
  assign fmt_ok = wbuf[0][0] & wbuf[1][0] & wbuf[2][0] & wbuf[3][0]
                & (wbuf[4][2:0] == 3'b100)
                & (wbuf[4][15:11] == {5{wbuf[4][10]}})
                & (in_word[6:0] == 7'd0);

  assign rec = {in_word[15:7], wbuf[4][10:3], wbuf[3][15:1], wbuf[2][15:1],
                wbuf[1][15:1], wbuf[0][15:1]};

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    store       = 1'b0;
    frame_err_c = 1'b0;
    fmt_err_c   = 1'b0;
    push_rec    = 1'b0;
    push_ee     = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_dv) begin
          if (in_ev) begin
            frame_err_c = 1'b1;
          end else begin
            store   = 1'b1;
            cnt_n   = 3'd1;
            state_n = COLLECT;
          end
        end else if (in_ee) begin
          push_ee = 1'b1;
        end
      end
      COLLECT: begin
        state_n = IDLE;
        cnt_n   = 3'd0;
        if (in_dv && !in_ev && cnt < 3'd5) begin
          store   = 1'b1;
          cnt_n   = cnt + 3'd1;
          state_n = COLLECT;
        end else if (in_dv && in_ev && cnt == 3'd5) begin
          if (fmt_ok) push_rec  = 1'b1;
          else        fmt_err_c = 1'b1;
        end else begin
          frame_err_c = 1'b1;
          push_ee     = !in_dv && in_ee;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      frame_err <= 1'b0;
      fmt_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      frame_err <= frame_err_c;
      fmt_err   <= fmt_err_c;
    end
  end

  always_ff @(posedge clock) begin
    if (store) wbuf[cnt] <= in_word;
  end

  assign push      = push_rec | push_ee;
  assign push_data = push_ee ? {1'b1, 77'd0} : {1'b0, rec};
  assign out_valid = (fifo_level != '0);
  assign full      = (fifo_level == FULL_LVL);
  assign pop       = out_valid & out_ready;
  assign push_ok   = push & (~full | pop);
  assign out_rec   = out_valid ? mem[rd_ptr][76:0] : '0;
  assign out_is_ee = out_valid & mem[rd_ptr][77];

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (!push_ok && pop) fifo_level <= fifo_level - 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hit_deserializer_45.sv
// Directed bench for hit_deserializer_45: vector table plus hand-written multi-cycle sequences.
module tb_hit_deserializer_45;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] in_word;
  logic        in_dv, in_ev, in_ee;
  logic [76:0] out_rec;
  logic        out_is_ee, out_valid, out_ready;
  logic        frame_err, fmt_err, overflow;
  logic [2:0]  fifo_level;

  hit_deserializer_45 #(.DEPTH(4), .AW(2)) dut (
    .clock(clock), .reset(reset), .in_word(in_word), .in_dv(in_dv), .in_ev(in_ev),
    .in_ee(in_ee), .out_rec(out_rec), .out_is_ee(out_is_ee), .out_valid(out_valid),
    .out_ready(out_ready), .frame_err(frame_err), .fmt_err(fmt_err),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [77:0] popq [$];
  int unsigned max_lvl;

  localparam logic [76:0] REC1 = {9'h035, 8'h81, 15'd4, 15'd3, 15'd2, 15'd1};
  localparam logic [76:0] REC2 = {9'h1FF, 8'h10, 15'd8, 15'd7, 15'd6, 15'd5};
  localparam logic [95:0] F1   = {16'h1A80, 16'hFC0C, 16'h0009, 16'h0007, 16'h0005, 16'h0003};
  localparam logic [95:0] F2   = {16'hFF80, 16'h0084, 16'h0011, 16'h000F, 16'h000D, 16'h000B};

  typedef struct {
    logic dv, ev, ee, rdy;
    logic [15:0] w;
    logic e_valid, e_ee, e_ferr, e_fmterr;
    logic [2:0] e_lvl;
  } vec_t;
  vec_t vt [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pops are recorded as seen just before the edge that performs them.
  task automatic cycle();
    if (out_valid && out_ready) popq.push_back({out_is_ee, out_rec});
    @(posedge clock);
    #1;
    if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
  endtask

  task automatic drive(input logic dv, input logic ev, input logic ee, input logic [15:0] w);
    in_dv = dv; in_ev = ev; in_ee = ee; in_word = w;
  endtask

  task automatic send(input logic [95:0] f);
    logic [95:0] ff;
    ff = f;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, k == 5, 1'b0, ff[16*k +: 16]);
      cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  function automatic vec_t mk(input logic dv, ev, ee, rdy, input logic [15:0] w,
                              input logic v, ise, fe, me, input logic [2:0] lvl);
    vec_t r;
    r.dv = dv; r.ev = ev; r.ee = ee; r.rdy = rdy; r.w = w;
    r.e_valid = v; r.e_ee = ise; r.e_ferr = fe; r.e_fmterr = me; r.e_lvl = lvl;
    return r;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_is_ee"}, 128'(out_is_ee), 128'(0));
    chk({tag, "_rec"}, 128'(out_rec), 128'(0));
    chk({tag, "_ferr"}, 128'(frame_err), 128'(0));
    chk({tag, "_fmterr"}, 128'(fmt_err), 128'(0));
    chk({tag, "_ovf"}, 128'(overflow), 128'(0));
    chk({tag, "_lvl"}, 128'(fifo_level), 128'(0));
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b0; max_lvl = 0;
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    cycle(); cycle();
    check_idle_outputs("reset");
    reset = 1'b0;

    // Single valid frame, head visible one cycle after the ev word.
    send(F1);
    chk("f1_valid", 128'(out_valid), 128'(1));
    chk("f1_rec", 128'(out_rec), 128'(REC1));
    chk("f1_is_ee", 128'(out_is_ee), 128'(0));
    chk("f1_errs", 128'({frame_err, fmt_err}), 128'(0));
    out_ready = 1'b1; cycle();
    chk("f1_popped", 128'(fifo_level), 128'(0));
    out_ready = 1'b0;

    // ev on 4th word, then a normal frame
    vt.push_back(mk(1,0,0,0,16'h0003, 0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,16'h0005, 0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,16'h0007, 0,0,0,0,0));
    vt.push_back(mk(1,1,0,0,16'h0009, 0,0,1,0,0));
    vt.push_back(mk(1,0,0,0,16'h0003, 0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,16'h0005, 0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,16'h0007, 0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,16'h0009, 0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,16'hFC0C, 0,0,0,0,0));
    vt.push_back(mk(1,1,0,0,16'h1A80, 1,0,0,0,1));
    vt.push_back(mk(0,0,0,1,16'h0000, 0,0,0,0,0));
    // word5 low bits nonzero
    vt.push_back(mk(1,0,0,0,16'h0003, 0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,16'h0005, 0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,16'h0007, 0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,16'h0009, 0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,16'hFC0C, 0,0,0,0,0));
    vt.push_back(mk(1,1,0,0,16'h1A81, 0,0,0,1,0));
    // word1 bit0 clear, back-to-back with the previous frame
    vt.push_back(mk(1,0,0,0,16'h0003, 0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,16'h0004, 0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,16'h0007, 0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,16'h0009, 0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,16'hFC0C, 0,0,0,0,0));
    vt.push_back(mk(1,1,0,0,16'h1A80, 0,0,0,1,0));
    // dv drops after word 2 with ee: frame error and marker together
    vt.push_back(mk(1,0,0,0,16'h0003, 0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,16'h0005, 0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,16'h0007, 0,0,0,0,0));
    vt.push_back(mk(0,0,1,0,16'h0000, 1,1,1,0,1));
    vt.push_back(mk(0,0,0,1,16'h0000, 0,0,0,0,0));
    // ev alone in IDLE
    vt.push_back(mk(1,1,0,0,16'h0003, 0,0,1,0,0));
    // six words without ev
    vt.push_back(mk(1,0,0,0,16'h0003, 0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,16'h0005, 0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,16'h0007, 0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,16'h0009, 0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,16'hFC0C, 0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,16'h1A80, 0,0,1,0,0));
    // ee ignored alongside dv in IDLE; the started frame then breaks
    vt.push_back(mk(1,0,1,0,16'h0003, 0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,16'h0000, 0,0,1,0,0));
    // lone ee in IDLE
    vt.push_back(mk(0,0,1,0,16'h0000, 1,1,0,0,1));
    vt.push_back(mk(0,0,0,1,16'h0000, 0,0,0,0,0));

    foreach (vt[i]) begin
      drive(vt[i].dv, vt[i].ev, vt[i].ee, vt[i].w);
      out_ready = vt[i].rdy;
      cycle();
      chk($sformatf("vec%0d_valid", i), 128'(out_valid), 128'(vt[i].e_valid));
      chk($sformatf("vec%0d_is_ee", i), 128'(out_is_ee), 128'(vt[i].e_ee));
      chk($sformatf("vec%0d_ferr", i), 128'(frame_err), 128'(vt[i].e_ferr));
      chk($sformatf("vec%0d_fmterr", i), 128'(fmt_err), 128'(vt[i].e_fmterr));
      chk($sformatf("vec%0d_lvl", i), 128'(fifo_level), 128'(vt[i].e_lvl));
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    out_ready = 1'b0;
    cycle();

    // Back-to-back frames then ee with downstream always ready
    popq.delete(); max_lvl = 0; out_ready = 1'b1;
    send(F1);
    send(F2);
    drive(1'b0, 1'b0, 1'b1, 16'h0); cycle();
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    for (int k = 0; k < 3; k++) cycle();
    chk("b2b_npops", 128'(popq.size()), 128'(3));
    if (popq.size() == 3) begin
      chk("b2b_pop0", 128'(popq[0]), 128'({1'b0, REC1}));
      chk("b2b_pop1", 128'(popq[1]), 128'({1'b0, REC2}));
      chk("b2b_pop2", 128'(popq[2]), 128'({1'b1, 77'd0}));
    end
    chk("b2b_maxlvl_le2", 128'(max_lvl <= 2), 128'(1));
    chk("b2b_errs", 128'({frame_err, fmt_err, overflow}), 128'(0));

    // Overflow: five frames into a 4-deep FIFO with no pops
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) send(F2);
    chk("ovf_lvl", 128'(fifo_level), 128'(4));
    chk("ovf_flag", 128'(overflow), 128'(1));
    popq.delete(); out_ready = 1'b1;
    for (int k = 0; k < 6; k++) cycle();
    chk("ovf_npops", 128'(popq.size()), 128'(4));
    foreach (popq[i]) chk($sformatf("ovf_pop%0d", i), 128'(popq[i]), 128'({1'b0, REC2}));
    chk("ovf_sticky", 128'(overflow), 128'(1));
    chk("ovf_drained", 128'(fifo_level), 128'(0));

    // Reset mid-frame with an entry queued, then a clean frame
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 16'h0); cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 16'h0003); cycle();
    end
    reset = 1'b1; drive(1'b0, 1'b0, 1'b0, 16'h0); cycle();
    check_idle_outputs("midrst");
    reset = 1'b0;
    send(F2);
    chk("post_rst_lvl", 128'(fifo_level), 128'(1));
    chk("post_rst_rec", 128'(out_rec), 128'(REC2));
    chk("post_rst_errs", 128'({frame_err, fmt_err, overflow, out_is_ee}), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
